uart_line_buffer: RTL and testbench

//  Line-assembling character buffer on the simulation console path. Sits between the
//  SoC top's io_uart_out_valid/io_uart_out_ch and the testbench's console printer.
//  It collects characters into a FIFO and releases them only as complete lines, ended by

---
 rtl/uart_line_buffer_if.sv | 23 ++
 rtl/uart_line_buffer.sv | 64 ++++++
 tb/tb_uart_line_buffer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_line_buffer_if.sv
// uart_line_buffer_if: SoC character strobe in, line-framed console stream out
interface uart_line_buffer_if #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
);
    logic                     uart_out_valid;
    logic [7:0]               uart_out_ch;
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               out_ch;
    logic                     out_last;
    logic [$clog2(DEPTH):0]   lines_pending;
    logic                     overflow;
    logic [CNT_W-1:0]         drop_count;
    modport master (
        output uart_out_valid, uart_out_ch, out_ready,
        input  out_valid, out_ch, out_last, lines_pending, overflow, drop_count
    );
    modport slave (
        input  uart_out_valid, uart_out_ch, out_ready,
        output out_valid, out_ch, out_last, lines_pending, overflow, drop_count
    );
endinterface

// File: rtl/uart_line_buffer.sv
// uart_line_buffer: FIFO that releases console characters only as complete lines
module uart_line_buffer #(
    parameter int DEPTH    = 256,
    parameter int MAX_LINE = 128,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_W    = 16
) (
    input logic              clock,
    input logic              reset,
    uart_line_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(MAX_LINE + 1);
    localparam int IW = $clog2(TIMEOUT);
    logic [8:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, lines_pending;
    logic [LW-1:0]    cur_len;
    logic [IW-1:0]    idle_cnt;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;
    logic             full, push, drop, push_last, pop, pop_last, close, out_valid;
    assign out_valid = lines_pending != '0;
    assign full      = count == (AW+1)'(DEPTH);
    assign push      = bus.uart_out_valid && !full;
    assign drop      = bus.uart_out_valid && full;
    assign push_last = push && (bus.uart_out_ch == 8'h0A || cur_len == LW'(MAX_LINE - 1));
    assign pop       = out_valid && bus.out_ready;
    assign pop_last  = pop && mem[rd_ptr][8];
    // A full FIFO with no complete line could never drain, so close the partial line
    assign close     = !push && cur_len != '0 &&
                       (idle_cnt == IW'(TIMEOUT - 1) || (full && lines_pending == '0));
    assign bus.out_valid     = out_valid;
    assign bus.out_ch        = out_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign bus.out_last      = out_valid ? mem[rd_ptr][8] : 1'b0;
    assign bus.lines_pending = lines_pending;
    assign bus.overflow      = overflow;
    assign bus.drop_count    = drop_count;
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {push_last, bus.uart_out_ch};
        if (close) mem[wr_ptr - 1'b1][8] <= 1'b1;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            lines_pending <= '0;
            cur_len       <= '0;
            idle_cnt      <= '0;
            overflow      <= 1'b0;
            drop_count    <= '0;
        end else begin
            wr_ptr        <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr        <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count         <= count + (AW+1)'(push) - (AW+1)'(pop);
            lines_pending <= lines_pending + (AW+1)'(push_last || close) - (AW+1)'(pop_last);
            cur_len       <= (push_last || close) ? '0 : push ? cur_len + 1'b1 : cur_len;
            idle_cnt      <= (push || close) ? '0 : cur_len != '0 ? idle_cnt + 1'b1 : idle_cnt;
            overflow      <= overflow | drop;
            drop_count    <= (drop && drop_count != '1) ? drop_count + 1'b1 : drop_count;
        end
    end
endmodule

// File: tb/tb_uart_line_buffer.sv
// tb_uart_line_buffer: directed stimulus with a queue scoreboard per DUT instance
module tb_uart_line_buffer;
    logic clock = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] e0, e1;
    always #5 clock = ~clock;
    uart_line_buffer_if #(.DEPTH(256), .CNT_W(16)) b0 ();
    uart_line_buffer_if #(.DEPTH(16),  .CNT_W(16)) b1 ();
    uart_line_buffer #(.DEPTH(256), .MAX_LINE(128), .TIMEOUT(1024), .CNT_W(16)) d0 (
        .clock(clock), .reset(reset), .bus(b0)
    );
    uart_line_buffer #(.DEPTH(16), .MAX_LINE(32), .TIMEOUT(1024), .CNT_W(16)) d1 (
        .clock(clock), .reset(reset), .bus(b1)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clock) begin
        if (!reset && b0.out_valid && b0.out_ready) begin
            if (q0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL d0 spurious output: got %0h, expected none", {b0.out_last, b0.out_ch});
            end else begin
                e0 = q0.pop_front();
                chk("d0 stream", {23'd0, b0.out_last, b0.out_ch}, {23'd0, e0});
            end
        end
        if (!reset && b1.out_valid && b1.out_ready) begin
            if (q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL d1 spurious output: got %0h, expected none", {b1.out_last, b1.out_ch});
            end else begin
                e1 = q1.pop_front();
                chk("d1 stream", {23'd0, b1.out_last, b1.out_ch}, {23'd0, e1});
            end
        end
    end
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic send0(input logic [7:0] c, input bit stored, input bit last);
        if (stored) q0.push_back({last, c});
        b0.uart_out_valid = 1'b1;
        b0.uart_out_ch    = c;
        tick();
        b0.uart_out_valid = 1'b0;
    endtask
    task automatic send1(input logic [7:0] c, input bit stored, input bit last);
        if (stored) q1.push_back({last, c});
        b1.uart_out_valid = 1'b1;
        b1.uart_out_ch    = c;
        tick();
        b1.uart_out_valid = 1'b0;
    endtask
    task automatic wait_q0(input int bound);
        int k = 0;
        while (q0.size() != 0 && k < bound) begin
            tick();
            k++;
        end
        chk("d0 drained within bound", q0.size(), 0);
    endtask
    task automatic wait_q1(input int bound);
        int k = 0;
        while (q1.size() != 0 && k < bound) begin
            tick();
            k++;
        end
        chk("d1 drained within bound", q1.size(), 0);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        reset = 1'b1;
        b0.uart_out_valid = 1'b0; b0.uart_out_ch = 8'h00; b0.out_ready = 1'b0;
        b1.uart_out_valid = 1'b0; b1.uart_out_ch = 8'h00; b1.out_ready = 1'b0;
        repeat (2) tick();
        chk("reset d0 out_valid", b0.out_valid, 0);
        chk("reset d0 out_ch", b0.out_ch, 0);
        chk("reset d0 lines_pending", b0.lines_pending, 0);
        chk("reset d0 overflow", b0.overflow, 0);
        chk("reset d0 drop_count", b0.drop_count, 0);
        chk("reset d1 out_valid", b1.out_valid, 0);
        chk("reset d1 lines_pending", b1.lines_pending, 0);
        reset = 1'b0;
        tick();
        // Test 1: "Hi\n" with consumer always ready
        b0.out_ready = 1'b1;
        send0(8'h48, 1, 0);
        send0(8'h69, 1, 0);
        chk("t1 no line before newline", b0.lines_pending, 0);
        send0(8'h0A, 1, 1);
        chk("t1 lines_pending after newline", b0.lines_pending, 1);
        wait_q0(10);
        chk("t1 lines_pending drained", b0.lines_pending, 0);
        // Test 2: 130 chars without newline: 128-char cap line then timed-out 2-char line
        for (int i = 0; i < 130; i++) send0(8'h41, 1, i == 127 || i == 129);
        repeat (200) tick();
        chk("t2 partial held", b0.out_valid, 0);
        chk("t2 partial left in queue", q0.size(), 2);
        wait_q0(1100);
        chk("t2 lines_pending after timeout drain", b0.lines_pending, 0);
        // Test 3: held output is stable while not ready
        b0.out_ready = 1'b0;
        send0(8'h41, 1, 0);
        send0(8'h42, 1, 0);
        send0(8'h0A, 1, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3 out_valid held", b0.out_valid, 1);
            chk("t3 out_ch held", b0.out_ch, 8'h41);
        end
        b0.out_ready = 1'b1;
        wait_q0(3);
        // Test 4: overflow with consumer stalled
        b0.out_ready = 1'b0;
        for (int i = 0; i < 260; i++) begin
            logic [7:0] c;
            c = (i % 10 == 9) ? 8'h0A : 8'(8'h30 + i % 10);
            send0(c, i < 256, c == 8'h0A || i == 255);
        end
        chk("t4 lines_pending", b0.lines_pending, 25);
        chk("t4 drop_count", b0.drop_count, 4);
        chk("t4 overflow", b0.overflow, 1);
        chk("t4 head char", b0.out_ch, 8'h30);
        b0.out_ready = 1'b1;
        wait_q0(1200);
        chk("t4 lines_pending drained", b0.lines_pending, 0);
        // Test 5: small FIFO fills with no newline and force-closes
        b1.out_ready = 1'b0;
        for (int i = 0; i < 17; i++) send1(8'(8'h61 + i), i < 16, i == 15);
        chk("t5 lines_pending forced", b1.lines_pending, 1);
        chk("t5 drop_count", b1.drop_count, 1);
        chk("t5 overflow", b1.overflow, 1);
        b1.out_ready = 1'b1;
        wait_q1(20);
        chk("t5 lines_pending drained", b1.lines_pending, 0);
        // Test 6: reset while draining a 5-char line
        b0.out_ready = 1'b0;
        send0(8'h70, 1, 0);
        send0(8'h71, 1, 0);
        send0(8'h72, 1, 0);
        send0(8'h73, 1, 0);
        send0(8'h0A, 1, 1);
        b0.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("t6 out_valid at reset", b0.out_valid, 0);
        chk("t6 out_ch at reset", b0.out_ch, 0);
        chk("t6 out_last at reset", b0.out_last, 0);
        chk("t6 lines_pending at reset", b0.lines_pending, 0);
        chk("t6 overflow at reset", b0.overflow, 0);
        chk("t6 drop_count at reset", b0.drop_count, 0);
        q0.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        send0(8'h58, 1, 0);
        send0(8'h0A, 1, 1);
        wait_q0(10);
        repeat (5) tick();
        chk("t6 nothing extra pending", b0.lines_pending, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
